// File: rtl/inter_board_link_pkg.sv
// Shared definitions for the inter-board link transmitter and receiver: header layout,
// frame types, FSM states and beat-count helper.
package inter_board_link_pkg;

  localparam int unsigned HdrFlyingBit = 0;
  localparam int unsigned HdrOddBit    = 1;
  localparam int unsigned HdrTypeBit   = 2;

  localparam logic FrameData   = 1'b1;
  localparam logic FrameStatus = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload
  } link_state_e;

  function automatic int unsigned num_beats(input int unsigned width,
                                            input int unsigned link_width);
    return (width + link_width - 1) / link_width;
  endfunction

endpackage

// File: rtl/link_beat_mux.sv
// Selects payload beat beat_cnt (LSB-first) from a held word; the last beat is zero-padded.
module link_beat_mux #(
  parameter int unsigned DATA_WIDTH = 25,
  parameter int unsigned LINK_WIDTH = 8,
  parameter int unsigned NUM_BEATS  = 4,
  parameter int unsigned CNT_WIDTH  = 2
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [LINK_WIDTH-1:0] beat
);

  localparam int unsigned PaddedWidth = NUM_BEATS * LINK_WIDTH;

  logic [PaddedWidth-1:0] padded;

  always_comb begin
    padded                   = '0;
    padded[DATA_WIDTH-1:0]   = data;
    beat                     = '0;
    for (int unsigned i = 0; i < NUM_BEATS; i++) begin
      if (beat_cnt == CNT_WIDTH'(i)) begin
        beat = padded[i*LINK_WIDTH +: LINK_WIDTH];
      end
    end
  end

endmodule

// File: rtl/inter_board_link_tx.sv
// Transmit half of the inter-board link: frames held words and local flags onto a narrow channel.
// Defining LINK_PARITY_EN adds an even-parity output accompanying every beat.
module inter_board_link_tx
  import inter_board_link_pkg::*;
#(
  parameter int unsigned CODE_DISTANCE_X = 5,
  parameter int unsigned CODE_DISTANCE_Z = 4,
  parameter int unsigned LINK_WIDTH      = 8,
  localparam int unsigned MaxDistance    = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ?
                                           CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int unsigned FINAL_FIFO_WIDTH = 2 * 3 * $clog2(MaxDistance) + 2 +
                                             $clog2(MaxDistance * CODE_DISTANCE_Z),
  localparam int unsigned NUM_BEATS      = num_beats(FINAL_FIFO_WIDTH, LINK_WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [FINAL_FIFO_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        has_message_flying,
  input  logic                        has_odd_clusters,
  output logic [LINK_WIDTH-1:0]       link_data,
  output logic                        link_valid,
  input  logic                        link_ready,
  output logic                        tx_busy
`ifdef LINK_PARITY_EN
  ,
  output logic                        link_parity
`endif
);

  localparam int unsigned BeatCntW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BeatCntW-1:0] LastBeat = BeatCntW'(NUM_BEATS - 1);

  link_state_e                 state;
  logic                        hold_valid;
  logic [FINAL_FIFO_WIDTH-1:0] hold_data;
  logic [BeatCntW-1:0]         beat_cnt;
  logic [1:0]                  hdr_status;
  logic [1:0]                  last_sent;
  logic                        hdr_type;

  logic [1:0]                  flags;
  logic                        link_hs;
  logic [LINK_WIDTH-1:0]       header_beat;
  logic [LINK_WIDTH-1:0]       payload_beat;

  // Flags packed as {odd, flying} to match header bit order.
  assign flags    = {has_odd_clusters, has_message_flying};
  assign in_ready = !hold_valid && reset;
  assign link_hs  = link_valid && link_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= StIdle;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      beat_cnt   <= '0;
      hdr_status <= 2'b00;
      last_sent  <= 2'b00;
      hdr_type   <= FrameStatus;
    end else begin
      if (in_valid && in_ready) begin
        hold_data  <= in_data;
        hold_valid <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (hold_valid) begin
            state      <= StHeader;
            hdr_type   <= FrameData;
            hdr_status <= flags;
          end else if (flags != last_sent) begin
            state      <= StHeader;
            hdr_type   <= FrameStatus;
            hdr_status <= flags;
          end
        end
        StHeader: begin
          if (link_hs) begin
            last_sent <= hdr_status;
            if (hdr_type == FrameData) begin
              state    <= StPayload;
              beat_cnt <= '0;
            end else begin
              state <= StIdle;
            end
          end
        end
        StPayload: begin
          if (link_hs) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LastBeat) begin
              hold_valid <= 1'b0;
              state      <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  link_beat_mux #(
    .DATA_WIDTH (FINAL_FIFO_WIDTH),
    .LINK_WIDTH (LINK_WIDTH),
    .NUM_BEATS  (NUM_BEATS),
    .CNT_WIDTH  (BeatCntW)
  ) u_beat_mux (
    .data     (hold_data),
    .beat_cnt (beat_cnt),
    .beat     (payload_beat)
  );

  always_comb begin
    header_beat               = '0;
    header_beat[HdrFlyingBit] = hdr_status[0];
    header_beat[HdrOddBit]    = hdr_status[1];
    header_beat[HdrTypeBit]   = hdr_type;
  end

  always_comb begin
    link_data = '0;
    unique case (state)
      StHeader:  link_data = header_beat;
      StPayload: link_data = payload_beat;
      default:   link_data = '0;
    endcase
  end

  assign link_valid = (state != StIdle);
  assign tx_busy    = hold_valid || (state != StIdle);

`ifdef LINK_PARITY_EN
  assign link_parity = ^link_data;
`endif

endmodule

// File: tb/tb_inter_board_link_tx.sv
// Scoreboard bench for inter_board_link_tx: expected beats are queued as stimulus is driven and
// checked in order by a monitor; exercises LINK_PARITY_EN when that macro is defined.
module tb_inter_board_link_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        fly;
  logic        odd;
  logic [7:0]  link_data;
  logic        link_valid;
  logic        link_ready;
  logic        tx_busy;
`ifdef LINK_PARITY_EN
  logic        link_parity;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  logic [24:0] d3, d4, d5;

  always #5 clk = ~clk;

  inter_board_link_tx dut (
    .clk                (clk),
    .reset              (reset),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .has_message_flying (fly),
    .has_odd_clusters   (odd),
    .link_data          (link_data),
    .link_valid         (link_valid),
    .link_ready         (link_ready),
    .tx_busy            (tx_busy)
`ifdef LINK_PARITY_EN
    ,
    .link_parity        (link_parity)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Header layout: {5'b0, type, odd, flying}; payload LSB-first, zero-padded to 32 bits.
  task automatic push_frame(input logic [1:0] fl, input logic [24:0] d);
    logic [31:0] padded;
    padded = {7'b0, d};
    sb.push_back({5'b0, 1'b1, fl});
    for (int i = 0; i < 4; i++) sb.push_back(padded[8*i +: 8]);
  endtask

  task automatic push_status(input logic [1:0] fl);
    sb.push_back({5'b0, 1'b0, fl});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic accept_word(input logic [24:0] d);
    int n;
    n        = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || tx_busy || link_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
    check({tag, "_idle"}, tx_busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid beat must match the scoreboard head; pop on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && link_valid) begin
        check("beat_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          check("beat_data", link_data, sb[0]);
`ifdef LINK_PARITY_EN
          check("beat_parity", link_parity, ^sb[0]);
`endif
          if (link_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    fly        = 1'b0;
    odd        = 1'b0;
    link_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_link_valid", link_valid, 0);
    check("rst_link_data", link_data, 0);
    check("rst_tx_busy", tx_busy, 0);
`ifdef LINK_PARITY_EN
    check("rst_parity", link_parity, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_link_valid", link_valid, 0);
    @(posedge clk);
    #1;

    // DATA frame with free-flowing link; flags raised after accept so the data header carries them.
    sb.push_back(8'h05);
    sb.push_back(8'hEF);
    sb.push_back(8'hCD);
    sb.push_back(8'hAB);
    sb.push_back(8'h01);
    accept_word(25'h1ABCDEF);
    fly = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t1_in_ready_low", in_ready, 0);
      if (i == 0) check("t1_idle_accept_cycle", link_valid, 0);
      if (i == 1) begin
        check("t1_header_valid", link_valid, 1);
        check("t1_busy", tx_busy, 1);
      end
    end
    @(negedge clk);
    check("t1_in_ready_back", in_ready, 1);
    @(posedge clk);
    #1;
    drain("t1_drain");

    // Backpressure on the third beat (8'hCD) for three cycles.
    push_frame(2'b01, 25'h1ABCDEF);
    accept_word(25'h1ABCDEF);
    repeat (3) @(posedge clk);
    #1 link_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 link_ready = 1'b1;
    drain("t2_drain");

    // Status frames: 01->00 then 00->10, then silence while flags hold.
    fly = 1'b0;
    push_status(2'b00);
    drain("t3a_drain");
    push_status(2'b10);
    odd = 1'b1;
    @(negedge clk);
    check("t3_status_not_yet", link_valid, 0);
    @(negedge clk);
    check("t3_status_next_cycle", link_valid, 1);
    drain("t3b_drain");
    repeat (10) @(negedge clk);
    check("t3_quiet", tx_busy, 0);
    check("t3_quiet_sb", sb.size(), 0);
    @(posedge clk);
    #1;

    // Flag change 01->11 during payload: frame header unchanged, STATUS 8'h03 follows.
    {odd, fly} = 2'b01;
    push_status(2'b01);
    drain("t4a_pre");
    push_frame(2'b01, 25'h0123456);
    push_status(2'b11);
    accept_word(25'h0123456);
    repeat (3) @(posedge clk);
    #1 {odd, fly} = 2'b11;
    drain("t4a_drain");

    // Word queued during a frame, flags change as it is accepted: DATA header 8'h07 wins.
    {odd, fly} = 2'b01;
    push_status(2'b01);
    drain("t4b_pre");
    d3 = 25'($urandom);
    d4 = 25'($urandom);
    push_frame(2'b01, d3);
    push_frame(2'b11, d4);
    accept_word(d3);
    accept_word(d4);
    {odd, fly} = 2'b11;
    drain("t4b_drain");

    // Reset during payload beat 2, flags high out of reset -> STATUS 8'h03.
    d5 = 25'($urandom);
    push_frame(2'b11, d5);
    accept_word(d5);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_link_valid", link_valid, 0);
    check("t5_rst_tx_busy", tx_busy, 0);
    check("t5_rst_in_ready", in_ready, 0);
    sb.delete();
    push_status(2'b11);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t5_in_ready_after", in_ready, 1);
    drain("t5_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
